// File: rtl/bus_pkg.sv
// Shared encodings and the command record for the lab SoC bus master.
package bus_pkg;

    localparam int BUS_DWIDTH = 32;

    localparam logic TRANS_IDLE   = 1'b0;
    localparam logic TRANS_NONSEQ = 1'b1;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef struct packed {
        logic                  write;
        logic [BUS_DWIDTH-1:0] addr;
        logic [BUS_DWIDTH-1:0] wdata;
    } bus_cmd_t;

endpackage

// File: rtl/bus_master_if.sv
// Master-port signals of the bus top: address phase, data phase and slave reply.
interface bus_master_if
    import bus_pkg::*;
#(
    parameter int DWidth = BUS_DWIDTH
);
    logic [DWidth-1:0] addr;
    logic              trans;
    logic              write;
    logic [DWidth-1:0] wdata;
    logic [DWidth-1:0] rdata;
    logic              resp;
    logic              ready;

    modport master (output addr, trans, write, wdata, input rdata, resp, ready);
    modport slave  (input addr, trans, write, wdata, output rdata, resp, ready);
endinterface

// File: rtl/bus_master.sv
// Initiator-side bus master: turns single read/write commands into pipelined
// address/data phases and returns one in-order response per command.
module bus_master
    import bus_pkg::*;
#(
    parameter int DWidth = BUS_DWIDTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [DWidth-1:0] cmd_addr_i,
    input  logic [DWidth-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    output logic [DWidth-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              busy_o,
    bus_master_if.master      bus
);

    logic              a_valid_q, a_valid_d;
    bus_cmd_t          a_q, a_d;
    logic              d_valid_q, d_valid_d;
    logic              d_write_q, d_write_d;
    logic [DWidth-1:0] d_wdata_q, d_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DWidth-1:0] rsp_rdata_q, rsp_rdata_d;

    logic retract;
    logic advance;
    logic accept;

    // First cycle of an ERROR reply pulls back the pipelined address phase.
    assign retract = d_valid_q & (bus.resp == RESP_ERROR);
    assign advance = bus.ready & ~retract;

    assign cmd_ready_o = ~rst_i & (~a_valid_q | advance);
    assign accept      = cmd_valid_i & cmd_ready_o;

    always_comb begin
        a_valid_d   = a_valid_q;
        a_d         = a_q;
        d_valid_d   = d_valid_q;
        d_write_d   = d_write_q;
        d_wdata_d   = d_wdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        if (advance) begin
            d_valid_d = a_valid_q;
            d_write_d = a_q.write;
            d_wdata_d = a_q.wdata;
        end else if (retract && bus.ready) begin
            d_valid_d = 1'b0;
        end

        if (accept) begin
            a_valid_d = 1'b1;
            a_d.write = cmd_write_i;
            a_d.addr  = cmd_addr_i;
            a_d.wdata = cmd_wdata_i;
        end else if (advance) begin
            a_valid_d = 1'b0;
        end

        rsp_valid_d = d_valid_q & bus.ready;
        if (rsp_valid_d) begin
            rsp_err_d   = bus.resp;
            rsp_rdata_d = d_write_q ? '0 : bus.rdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_valid_q   <= 1'b0;
            a_q         <= '0;
            d_valid_q   <= 1'b0;
            d_write_q   <= 1'b0;
            d_wdata_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_q         <= a_d;
            d_valid_q   <= d_valid_d;
            d_write_q   <= d_write_d;
            d_wdata_q   <= d_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.addr  = a_q.addr;
    assign bus.write = a_q.write;
    assign bus.trans = (a_valid_q & ~retract) ? TRANS_NONSEQ : TRANS_IDLE;
    assign bus.wdata = d_wdata_q;

    assign busy_o      = a_valid_q | d_valid_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master: directed scenarios with literal expectations plus a
// transaction-level model (command/response queues) checked every cycle.
module tb_bus_master;
    import bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_write, cmd_ready;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    always #5 clk = ~clk;

    bus_master_if #(.DWidth(32)) bus ();

    bus_master #(.DWidth(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .busy_o(busy), .bus(bus)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_s;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic cmd_s mk(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_s c;
        c.write = w; c.addr = a; c.wdata = d;
        return c;
    endfunction

    // Slave behaviour: read data is a fixed scramble of the address, the upper half is unmapped.
    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return a ^ 32'hDEAD_BEFF;
    endfunction

    function automatic logic is_err(input logic [31:0] a);
        return a[31];
    endfunction

    // ---------------- transaction model + per-cycle compare ----------------
    cmd_s        bus_q[$];
    cmd_s        rsp_q[$];
    int          outstanding = 0;
    bit          exp_pulse = 0;
    bit          dp_valid = 0;
    cmd_s        dp;
    int          dp_seq = 0;
    int          n_rsp = 0;
    bit          prev_ok = 0, prev_trans, prev_ready, prev_write, prev_dp;
    logic [31:0] prev_addr, prev_wdata;

    always @(negedge clk) begin
        cmd_s e;
        bit   cur_dp;
        if (rst) begin
            bus_q.delete();
            rsp_q.delete();
            outstanding = 0;
            exp_pulse   = 0;
            dp_valid    = 0;
            prev_ok     = 0;
        end else begin
            cur_dp = dp_valid;
            check("rsp_valid", 32'(rsp_valid), 32'(exp_pulse));
            if (exp_pulse && rsp_q.size() > 0) begin
                e = rsp_q.pop_front();
                if (rsp_valid) begin
                    check("rsp_rdata", rsp_rdata, e.write ? 32'h0 : slave_data(e.addr));
                    check("rsp_err", 32'(rsp_err), 32'(is_err(e.addr)));
                end
            end
            if (rsp_valid) n_rsp++;
            check("busy", 32'(busy), 32'(outstanding != 0));
            if (prev_ok && prev_trans && !prev_ready) begin
                check("addr_stable", bus.addr, prev_addr);
                check("write_stable", 32'(bus.write), 32'(prev_write));
            end
            if (prev_ok && prev_dp && !prev_ready)
                check("wdata_stable", bus.wdata, prev_wdata);

            exp_pulse = 0;
            if (dp_valid && bus.ready) begin
                if (dp.write) check("wdata", bus.wdata, dp.wdata);
                outstanding--;
                exp_pulse = 1;
                dp_valid  = 0;
            end
            if (bus.trans && bus.ready) begin
                if (bus_q.size() == 0) begin
                    check("spurious_trans", 32'(bus.trans), 32'h0);
                end else begin
                    e = bus_q.pop_front();
                    check("bus_addr", bus.addr, e.addr);
                    check("bus_write", 32'(bus.write), 32'(e.write));
                    dp       = e;
                    dp_valid = 1;
                    dp_seq++;
                end
            end
            if (cmd_valid && cmd_ready) begin
                e = mk(cmd_write, cmd_addr, cmd_wdata);
                bus_q.push_back(e);
                rsp_q.push_back(e);
                outstanding++;
            end
            prev_trans = bus.trans;  prev_ready = bus.ready;
            prev_addr  = bus.addr;   prev_write = bus.write;
            prev_wdata = bus.wdata;  prev_dp    = cur_dp;
            prev_ok    = 1;
        end
    end

    // ---------------- driver: command source and slave ----------------
    cmd_s pend[$];
    bit   acc_last = 0, presenting = 0, rnd_mode = 0;
    int   seen_seq = 0, wait_left = 0, err_stage = 0, force_waits = 0;

    logic        h_trans[64], h_cmdrdy[64], h_rspv[64], h_err[64], h_ready[64], h_resp[64], h_busy[64];
    logic [31:0] h_addr[64], h_wdata[64], h_rdata[64];
    int          hcnt = 0;

    task automatic slave_drive();
        if (dp_valid) begin
            if (dp_seq != seen_seq) begin
                seen_seq  = dp_seq;
                err_stage = 0;
                if (force_waits > 0) wait_left = force_waits;
                else if (rnd_mode && $urandom_range(9) < 3) wait_left = $urandom_range(3, 1);
                else wait_left = 0;
                force_waits = 0;
            end
            bus.rdata = slave_data(dp.addr);
            if (is_err(dp.addr)) begin
                bus.resp  = 1'b1;
                bus.ready = (err_stage == 1);
                err_stage = 1;
            end else if (wait_left > 0) begin
                bus.resp  = 1'b0;
                bus.ready = 1'b0;
                wait_left--;
            end else begin
                bus.resp  = 1'b0;
                bus.ready = 1'b1;
            end
        end else begin
            bus.ready = 1'b1;
            bus.resp  = rnd_mode && ($urandom_range(9) == 0);
            bus.rdata = $urandom;
        end
    endtask

    task automatic step(input bit rst_v);
        @(posedge clk); #1;
        rst = rst_v;
        if (acc_last) begin
            void'(pend.pop_front());
            presenting = 0;
        end
        if (pend.size() == 0) presenting = 0;
        else if (!presenting && (!rnd_mode || $urandom_range(3) != 0)) presenting = 1;
        cmd_valid = presenting;
        if (presenting) begin
            cmd_write = pend[0].write;
            cmd_addr  = pend[0].addr;
            cmd_wdata = pend[0].wdata;
        end
        slave_drive();
        @(negedge clk); #1;
        acc_last = cmd_valid && cmd_ready;
        if (hcnt < 64) begin
            h_trans[hcnt] = bus.trans;  h_addr[hcnt]  = bus.addr;  h_wdata[hcnt] = bus.wdata;
            h_cmdrdy[hcnt] = cmd_ready; h_rspv[hcnt]  = rsp_valid; h_rdata[hcnt] = rsp_rdata;
            h_err[hcnt]   = rsp_err;    h_ready[hcnt] = bus.ready; h_resp[hcnt]  = bus.resp;
            h_busy[hcnt]  = busy;
        end
        hcnt++;
    endtask

    function automatic int first_rsp(input int from);
        for (int i = from; i < hcnt && i < 64; i++) if (h_rspv[i]) return i;
        return 0;
    endfunction

    function automatic int count_rsp(input int from);
        int n = 0;
        for (int i = from; i < hcnt && i < 64; i++) if (h_rspv[i]) n++;
        return n;
    endfunction

    initial begin
        int n, m, r0, r1, budget, rsp_base;
        logic [31:0] a;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        bus.ready = 1'b1; bus.resp = 1'b0; bus.rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_trans", 32'(bus.trans), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_cmd_ready", 32'(cmd_ready), 32'h0);
        check("reset_addr", bus.addr, 32'h0);
        check("reset_wdata", bus.wdata, 32'h0);
        step(0);
        step(0);
        check("idle_cmd_ready", 32'(cmd_ready), 32'h1);

        // single read, zero wait states
        hcnt = 0;
        pend.push_back(mk(1'b0, 32'h0000_0010, 32'h0));
        repeat (7) step(0);
        n = 0;
        for (int i = 0; i < 7; i++) if (h_trans[i]) n++;
        check("t1_trans_cycles", 32'(n), 32'd1);
        check("t1_trans_at", 32'(h_trans[1]), 32'h1);
        r0 = first_rsp(0);
        check("t1_rsp_at", 32'(r0), 32'd3);
        check("t1_rdata", h_rdata[r0], 32'hDEAD_BEEF);
        check("t1_err", 32'(h_err[r0]), 32'h0);
        check("t1_rsp_count", 32'(count_rsp(0)), 32'd1);

        // back-to-back writes
        hcnt = 0;
        pend.push_back(mk(1'b1, 32'h10, 32'h1));
        pend.push_back(mk(1'b1, 32'h14, 32'h2));
        repeat (8) step(0);
        check("t2_trans_a", 32'(h_trans[1]), 32'h1);
        check("t2_trans_b", 32'(h_trans[2]), 32'h1);
        check("t2_addr_b", h_addr[2], 32'h14);
        check("t2_wdata_overlap", h_wdata[2], 32'h1);
        check("t2_rsp_count", 32'(count_rsp(0)), 32'd2);
        check("t2_rsp0", {30'h0, h_rspv[3], h_err[3]}, 32'h2);
        check("t2_rsp1", {30'h0, h_rspv[4], h_err[4]}, 32'h2);

        // read with 3 wait states while 0x20 waits in the address phase
        hcnt = 0;
        force_waits = 3;
        pend.push_back(mk(1'b0, 32'h40, 32'h0));
        pend.push_back(mk(1'b0, 32'h20, 32'h0));
        repeat (12) step(0);
        n = 0; m = 0;
        for (int i = 0; i < 12; i++) begin
            if (!h_ready[i]) n++;
            if (!h_ready[i] && h_trans[i] && h_addr[i] == 32'h20 && !h_cmdrdy[i]) m++;
        end
        check("t3_wait_cycles", 32'(n), 32'd3);
        check("t3_held_cycles", 32'(m), 32'd3);
        r0 = first_rsp(0);
        r1 = first_rsp(r0 + 1);
        check("t3_rsp0_at", 32'(r0), 32'd6);
        check("t3_rsp0_rdata", h_rdata[r0], 32'hDEAD_BEBF);
        check("t3_rsp1_at", 32'(r1), 32'd7);
        check("t3_rsp1_rdata", h_rdata[r1], 32'hDEAD_BEDF);

        // unmapped access followed by a read that gets retracted and re-issued
        hcnt = 0;
        pend.push_back(mk(1'b0, 32'h8000_0000, 32'h0));
        pend.push_back(mk(1'b0, 32'h10, 32'h0));
        repeat (10) step(0);
        n = 0; m = 0;
        for (int i = 0; i < 10; i++) begin
            if (h_trans[i] && h_addr[i] == 32'h10) n++;
            if (h_resp[i]) m++;
        end
        check("t4_reissue_once", 32'(n), 32'd1);
        check("t4_err_cycles", 32'(m), 32'd2);
        check("t4_retract_c1", 32'(h_trans[2]), 32'h0);
        check("t4_retract_c2", 32'(h_trans[3]), 32'h0);
        check("t4_reissue_at", {31'h0, h_trans[4]}, 32'h1);
        r0 = first_rsp(0);
        r1 = first_rsp(r0 + 1);
        check("t4_rsp0_at", 32'(r0), 32'd4);
        check("t4_rsp0_err", 32'(h_err[r0]), 32'h1);
        check("t4_rsp0_rdata", h_rdata[r0], 32'h5EAD_BEFF);
        check("t4_rsp1_at", 32'(r1), 32'd6);
        check("t4_rsp1_err", 32'(h_err[r1]), 32'h0);
        check("t4_rsp1_rdata", h_rdata[r1], 32'hDEAD_BEEF);

        // reset with one transfer in data phase and one in address phase
        hcnt = 0;
        pend.push_back(mk(1'b0, 32'h10, 32'h0));
        pend.push_back(mk(1'b0, 32'h14, 32'h0));
        step(0);
        step(0);
        step(1);
        step(0);
        repeat (4) step(0);
        check("t5_pre_trans", h_addr[2], 32'h14);
        check("t5_pre_busy", 32'(h_busy[2]), 32'h1);
        check("t5_trans", 32'(h_trans[3]), 32'h0);
        check("t5_busy", 32'(h_busy[3]), 32'h0);
        check("t5_cmd_ready", 32'(h_cmdrdy[3]), 32'h1);
        check("t5_no_rsp", 32'(count_rsp(3)), 32'd0);

        // random stream with wait states and unmapped accesses
        rnd_mode = 1;
        rsp_base = n_rsp;
        for (int i = 0; i < 200; i++) begin
            a = {22'h0, 8'($urandom_range(255)), 2'b00};
            if ($urandom_range(99) < 5) a[31] = 1'b1;
            pend.push_back(mk(1'($urandom_range(1)), a, $urandom));
        end
        budget = 0;
        while ((pend.size() != 0 || outstanding != 0) && budget < 6000) begin
            step(0);
            budget++;
        end
        check("rnd_timeout", 32'(budget < 6000), 32'h1);
        rnd_mode = 0;
        repeat (3) step(0);
        check("rnd_rsp_count", 32'(n_rsp - rsp_base), 32'd200);
        check("rnd_bus_q_empty", 32'(bus_q.size()), 32'd0);
        check("rnd_rsp_q_empty", 32'(rsp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
